// File: rtl/uart_pkg.sv
// Shared UART constants: parity mode encodings and the frame-width helper
// used to size frame storage from DATA_BITS and PARITY_MODE.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Start bit + data + optional parity + stop bit.
  function automatic int frame_w(input int data_bits, input int parity_mode);
    return data_bits + 2 + ((parity_mode != PARITY_NONE) ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// Combinational frame builder: {stop, [parity], data, start}, LSB sent first.
// Zero latency, no flow control; purely a function of the character.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter  int DATA_BITS   = 8,
  parameter  int PARITY_MODE = PARITY_NONE,
  localparam int FRAME_W     = frame_w(DATA_BITS, PARITY_MODE)
) (
  input  logic [DATA_BITS-1:0] data,
  output logic [FRAME_W-1:0]   frame
);

  generate
    if (PARITY_MODE == PARITY_NONE) begin : g_nopar
      assign frame = {1'b1, data, 1'b0};
    end else begin : g_par
      logic parity;
      assign parity = (PARITY_MODE == PARITY_ODD) ? ~(^data) : (^data);
      assign frame  = {1'b1, parity, data, 1'b0};
    end
  endgenerate

endmodule

// File: rtl/uart_tx_buffer.sv
// UART transmit buffer: frames characters on write and holds them in a register FIFO.
// Head frame visible the cycle after a push; wr_ready derives only from registered count.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter  int DATA_BITS   = 8,
  parameter  int DEPTH       = 4,
  parameter  int PARITY_MODE = PARITY_NONE,
  localparam int FRAME_W     = frame_w(DATA_BITS, PARITY_MODE),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 load_req,
  output logic [FRAME_W-1:0]   frame_out,
  output logic                 frame_valid,
  output logic [CNT_W-1:0]     count,
  input  logic                 clr_ovf,
  output logic                 overflow
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [FRAME_W-1:0] wr_frame;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;

  uart_tx_framer #(
    .DATA_BITS   (DATA_BITS),
    .PARITY_MODE (PARITY_MODE)
  ) u_framer (
    .data  (wr_data),
    .frame (wr_frame)
  );

  // Full-buffer pops never admit a same-cycle push: wr_ready ignores load_req.
  assign wr_ready    = (count < FULL_CNT);
  assign frame_valid = (count != '0);
  assign frame_out   = frame_valid ? mem[rd_ptr] : '1;
  assign push        = wr_valid && wr_ready;
  assign pop         = load_req && frame_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end

      // A refused write outranks a clear in the same cycle.
      if (wr_valid && !wr_ready) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage is not reset; count/frame_valid gate what is observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_frame;
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: even/odd/no-parity instances on shared stimulus, queue model + literals.
module tb_uart_tx_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       load_req = 1'b0;
  logic       clr_ovf = 1'b0;

  logic        rdy_e, rdy_o, rdy_n;
  logic        vld_e, vld_o, vld_n;
  logic        ovf_e, ovf_o, ovf_n;
  logic [2:0]  cnt_e, cnt_o, cnt_n;
  logic [10:0] fo_e, fo_o;
  logic [9:0]  fo_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DATA_BITS(8), .DEPTH(DEPTH), .PARITY_MODE(1)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(rdy_e),
    .load_req(load_req), .frame_out(fo_e), .frame_valid(vld_e), .count(cnt_e),
    .clr_ovf(clr_ovf), .overflow(ovf_e)
  );

  uart_tx_buffer #(.DATA_BITS(8), .DEPTH(DEPTH), .PARITY_MODE(2)) dut_odd (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(rdy_o),
    .load_req(load_req), .frame_out(fo_o), .frame_valid(vld_o), .count(cnt_o),
    .clr_ovf(clr_ovf), .overflow(ovf_o)
  );

  uart_tx_buffer #(.DATA_BITS(8), .DEPTH(DEPTH), .PARITY_MODE(0)) dut_none (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(rdy_n),
    .load_req(load_req), .frame_out(fo_n), .frame_valid(vld_n), .count(cnt_n),
    .clr_ovf(clr_ovf), .overflow(ovf_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame from the layout rules: stop at top, parity below it, data from bit 1, start 0.
  function automatic logic [31:0] exp_frame(input logic [7:0] d, input int mode);
    logic [31:0] f;
    int          w;
    w = (mode != 0) ? 11 : 10;
    f = (32'd1 << (w - 1)) | (32'(d) << 1);
    if (mode == 1) f = f | (32'(^d) << 9);
    if (mode == 2) f = f | (32'(~^d) << 9);
    return f;
  endfunction

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;

  function automatic logic [31:0] exp_out(input int mode);
    int w;
    w = (mode != 0) ? 11 : 10;
    if (q.size() == 0) return (32'd1 << w) - 1;
    return exp_frame(q[0], mode);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      logic full, do_push, do_pop;
      full    = (q.size() >= DEPTH);
      do_push = wr_valid && !full;
      do_pop  = load_req && (q.size() != 0);
      if (wr_valid && full) m_ovf = 1'b1;
      else if (clr_ovf)     m_ovf = 1'b0;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    chk("count",       32'(cnt_e), 32'(q.size()));
    chk("frame_valid", 32'(vld_e), 32'(q.size() != 0));
    chk("wr_ready",    32'(rdy_e), 32'(q.size() < DEPTH));
    chk("overflow",    32'(ovf_e), 32'(m_ovf));
    chk("frame_even",  32'(fo_e),  exp_out(1));
    chk("frame_odd",   32'(fo_o),  exp_out(2));
    chk("frame_none",  32'(fo_n),  exp_out(0));
    chk("count_odd",   32'(cnt_o), 32'(q.size()));
    chk("count_none",  32'(cnt_n), 32'(q.size()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pop();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_count",  32'(cnt_e), 32'd0);
    chk("rst_valid",  32'(vld_e), 32'd0);
    chk("rst_frame",  32'(fo_e),  32'h7FF);
    chk("rst_ready",  32'(rdy_e), 32'd1);
    chk("rst_ovf",    32'(ovf_e), 32'd0);
    #20 reset = 1'b1;

    // Parity formats, first push right after reset release
    push(8'h55);
    chk("even_55",  32'(fo_e),  32'h4AA);
    chk("even_vld", 32'(vld_e), 32'd1);
    chk("even_cnt", 32'(cnt_e), 32'd1);
    chk("odd_55",   32'(fo_o),  32'h6AA);
    chk("none_55",  32'(fo_n),  32'h2AA);
    pop();
    push(8'h07);
    chk("even_07",  32'(fo_e),  32'h60E);
    pop();

    // Fill, refused write, drain in order, pop on empty
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("full_ready", 32'(rdy_e), 32'd0);
    chk("full_count", 32'(cnt_e), 32'd4);
    push(8'h05);
    chk("ovf_set",    32'(ovf_e), 32'd1);
    chk("ovf_count",  32'(cnt_e), 32'd4);
    chk("drain_1", 32'(fo_e), 32'h602); pop();
    chk("ready_after_pop", 32'(rdy_e), 32'd1);
    chk("drain_2", 32'(fo_e), 32'h604); pop();
    chk("drain_3", 32'(fo_e), 32'h406); pop();
    chk("drain_4", 32'(fo_e), 32'h608); pop();
    chk("idle_frame", 32'(fo_e), 32'h7FF);
    pop();
    chk("empty_pop_cnt",   32'(cnt_e), 32'd0);
    chk("empty_pop_frame", 32'(fo_e),  32'h7FF);

    // Set beats clear; clear alone then takes effect
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    wr_data = 8'hEE; wr_valid = 1'b1; clr_ovf = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("ovf_set_wins", 32'(ovf_e), 32'd1);
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf_e), 32'd0);
    pop(); pop();
    chk("cnt_two", 32'(cnt_e), 32'd2);

    // Concurrent push/pop across the pointer wrap
    load_req = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h10 + 8'(i);
      tick();
    end
    load_req = 1'b0;
    wr_valid = 1'b0;
    chk("stream_cnt",  32'(cnt_e), 32'd2);
    chk("stream_head", 32'(fo_e),  32'h428);

    // Asynchronous reset between clock edges
    push(8'h30);
    chk("cnt_three", 32'(cnt_e), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(cnt_e), 32'd0);
    chk("mid_rst_valid", 32'(vld_e), 32'd0);
    chk("mid_rst_frame", 32'(fo_e),  32'h7FF);
    #3 reset = 1'b1;
    push(8'hA5);
    chk("post_rst_A5",  32'(fo_e),  32'h54A);
    chk("post_rst_cnt", 32'(cnt_e), 32'd1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per character; legal range 5..8.
REQ-002 Parameter DEPTH, default 4, meaning buffered character count; power of two, 2..16.
REQ-003 Parameter PARITY_MODE, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-004 Derived FRAME_W = DATA_BITS + 2 + (PARITY_MODE != 0); CNT_W = clog2(DEPTH+1).
REQ-005 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port wr_data, input, DATA_BITS: character to transmit.
REQ-008 Port wr_valid, input, 1 bit: wr_data is valid this cycle.
REQ-009 Port wr_ready, output, 1 bit: buffer can accept a character.
REQ-010 Port load_req, input, 1 bit: shift register is taking frame_out this cycle.
REQ-011 Port frame_out, output, FRAME_W: formatted frame, LSB transmitted first.
REQ-012 Port frame_valid, output, 1 bit: frame_out holds a buffered frame.
REQ-013 Port count, output, CNT_W: number of buffered frames.
REQ-014 Port clr_ovf, input, 1 bit: synchronous clear of overflow.
REQ-015 Port overflow, output, 1 bit: sticky flag for a write attempted while full.

Function
REQ-016 Frame layout: bit 0 = start bit 0; bits DATA_BITS:1 = wr_data, LSB first; then the parity bit if enabled; MSB = stop bit 1.
REQ-017 Parity bit = XOR of the data bits (even mode), or its inverse (odd mode).
REQ-018 Frames are formatted at write time, so each storage entry holds FRAME_W bits.
REQ-019 A push occurs when wr_valid && wr_ready; a pop occurs when load_req && frame_valid.
REQ-020 wr_ready = (count < DEPTH); it depends only on registered state, never on load_req.
REQ-021 frame_valid = (count != 0). frame_out = head entry when frame_valid, else all ones (idle line).
REQ-022 Latency: a character pushed in cycle N appears on frame_out/frame_valid in cycle N+1 when the buffer was empty.
REQ-023 Ordering is strictly FIFO; read and write pointers wrap modulo DEPTH.
REQ-024 Simultaneous push and pop (not full): both take effect and count is unchanged.
REQ-025 Pop when full frees one slot: wr_ready is high in the next cycle; a push in the same cycle is refused.
REQ-026 load_req while empty: no pop, pointers and count unchanged, frame_out stays all ones.
REQ-027 wr_valid && !wr_ready: data is dropped, state is unchanged, and overflow is set in the next cycle.
REQ-028 overflow clears on clr_ovf; if a set and a clear occur in the same cycle, set wins.

Reset
REQ-029 reset low asynchronously forces: pointers = 0, count = 0, overflow = 0, frame_valid = 0, frame_out = all ones, wr_ready = 1.
REQ-030 Reset mid-operation discards all buffered frames; storage contents need not be cleared.
REQ-031 The first push is accepted on the first rising edge after reset deasserts.

Structure
REQ-032 Package uart_pkg holds the PARITY_NONE/EVEN/ODD constants and a frame-width function.
REQ-033 Frame formatting is a combinational sub-module uart_tx_framer (DATA_BITS, PARITY_MODE) instantiated on the write path.
REQ-034 Storage is a register array, with no inferred RAM, so frame_out is available in the cycle after a write.

Verification (DATA_BITS=8, DEPTH=4 unless stated)
REQ-035 Even parity: push 0x55 -> next cycle frame_out = 0x4AA, frame_valid = 1, count = 1; push 0x07 -> stored frame 0x60E.
REQ-036 Odd parity: push 0x55 -> frame_out = 0x6AA. No parity: push 0x55 -> 10-bit frame_out = 0x2AA.
REQ-037 Push 0x01, 0x02, 0x03, 0x04 -> wr_ready = 0 and count = 4; push 0x05 -> dropped and overflow = 1; four pops return frames in order 1..4, then frame_out = all ones.
REQ-038 With count = 2, hold wr_valid and load_req high for 6 cycles -> count stays 2, and six frames leave in write order across the pointer wrap.
REQ-039 With count = 3, assert reset low between clock edges -> count = 0, frame_valid = 0, and frame_out = all ones immediately; push 0xA5 after release -> visible one cycle later.
REQ-040 With overflow set, assert clr_ovf together with a refused write -> overflow stays 1; clr_ovf alone on the next cycle -> overflow = 0.
